// File: rtl/alu_operand_stage_if.sv
// Decode/execute boundary bus for the ALU operand stage.
// The decode and execute sides drive through the master modport; the stage itself uses the slave modport.
interface alu_operand_stage_if #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 32,
    parameter int NUM_FWD = 3
);
    logic                      in_valid;
    logic                      in_ready;
    logic [4:0]                rs1_idx;
    logic [4:0]                rs2_idx;
    logic [XLEN-1:0]           reg_data0;
    logic [XLEN-1:0]           reg_data1;
    logic                      op0_sel;
    logic                      op1_sel;
    logic [ADDR_W-1:0]         pc;
    logic [XLEN-1:0]           sext_imm;
    logic [XLEN-1:0]           cimm;
    logic                      is_cinstr;
    logic                      is_link;
    logic                      is_sys;
    logic                      sel_amo_op;
    logic [XLEN-1:0]           amo_val;
    logic [NUM_FWD-1:0]        fwd_valid;
    logic [NUM_FWD-1:0]        fwd_pending;
    logic [5*NUM_FWD-1:0]      fwd_rd;
    logic [XLEN*NUM_FWD-1:0]   fwd_data;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [XLEN-1:0]           op0;
    logic [XLEN-1:0]           op1;
    logic                      hazard;
    logic [31:0]               hazard_cnt;

    modport master (
        output in_valid, rs1_idx, rs2_idx, reg_data0, reg_data1, op0_sel, op1_sel, pc,
               sext_imm, cimm, is_cinstr, is_link, is_sys, sel_amo_op, amo_val,
               fwd_valid, fwd_pending, fwd_rd, fwd_data, flush, out_ready,
        input  in_ready, out_valid, op0, op1, hazard, hazard_cnt
    );

    modport slave (
        input  in_valid, rs1_idx, rs2_idx, reg_data0, reg_data1, op0_sel, op1_sel, pc,
               sext_imm, cimm, is_cinstr, is_link, is_sys, sel_amo_op, amo_val,
               fwd_valid, fwd_pending, fwd_rd, fwd_data, flush, out_ready,
        output in_ready, out_valid, op0, op1, hazard, hazard_cnt
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Registered ALU operand selection at the decode->execute boundary.
// Resolves rs1/rs2 through the forwarding network (youngest source wins),
// stalls on load-use hazards and holds one instruction's operands until execute takes them.
module alu_operand_stage #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 32,
    parameter int NUM_FWD = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_operand_stage_if.slave   bus
);

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            rs1_pend;
    logic            rs2_pend;
    logic            rs1_used;
    logic            rs2_used;
    logic            hazard;
    logic            in_ready;
    logic            accept;
    logic [XLEN-1:0] pc_ext;
    logic [XLEN-1:0] op0_d, op0_q;
    logic [XLEN-1:0] op1_d, op1_q;
    logic            out_valid_d, out_valid_q;
    logic [31:0]     hazard_cnt_d, hazard_cnt_q;

    // Forwarding network: scan oldest to youngest so the lowest matching index overrides the rest.
    always_comb begin
        rs1_val  = bus.reg_data0;
        rs2_val  = bus.reg_data1;
        rs1_pend = 1'b0;
        rs2_pend = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (bus.fwd_valid[i] && (bus.fwd_rd[5*i +: 5] == bus.rs1_idx) && (bus.rs1_idx != 5'd0)) begin
                rs1_val  = bus.fwd_data[XLEN*i +: XLEN];
                rs1_pend = bus.fwd_pending[i];
            end
            if (bus.fwd_valid[i] && (bus.fwd_rd[5*i +: 5] == bus.rs2_idx) && (bus.rs2_idx != 5'd0)) begin
                rs2_val  = bus.fwd_data[XLEN*i +: XLEN];
                rs2_pend = bus.fwd_pending[i];
            end
        end
    end

    // Operand selection, hazard detection and handshake decisions.
    always_comb begin
        pc_ext              = '0;
        pc_ext[ADDR_W-1:0]  = bus.pc;

        rs1_used = !bus.sel_amo_op && bus.op0_sel;
        rs2_used = bus.sel_amo_op || (bus.op1_sel && !bus.is_link);
        // Only the winning source's pending bit matters; a stale older pending is shadowed.
        hazard   = bus.in_valid && ((rs1_used && rs1_pend) || (rs2_used && rs2_pend));
        in_ready = !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
        accept   = bus.in_valid && in_ready;

        if (bus.sel_amo_op)   op0_d = rs2_val;
        else if (bus.op0_sel) op0_d = rs1_val;
        else                  op0_d = pc_ext;

        if (bus.is_link)         op1_d = bus.is_cinstr ? XLEN'(2) : XLEN'(4);
        else if (bus.sel_amo_op) op1_d = bus.amo_val;
        else if (bus.op1_sel)    op1_d = rs2_val;
        else if (bus.is_sys)     op1_d = '0;
        else if (bus.is_cinstr)  op1_d = bus.cimm;
        else                     op1_d = bus.sext_imm;

        // Flush wins over everything; otherwise a consume without a new accept empties the stage.
        if (bus.flush)          out_valid_d = 1'b0;
        else if (accept)        out_valid_d = 1'b1;
        else if (bus.out_ready) out_valid_d = 1'b0;
        else                    out_valid_d = out_valid_q;

        hazard_cnt_d = hazard_cnt_q;
        if (hazard && (hazard_cnt_q != 32'hFFFF_FFFF))
            hazard_cnt_d = hazard_cnt_q + 32'd1;
    end

    // Stage registers: operands load only on accept; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            op0_q        <= '0;
            op1_q        <= '0;
            hazard_cnt_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            hazard_cnt_q <= hazard_cnt_d;
            if (accept) begin
                op0_q <= op0_d;
                op1_q <= op1_d;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.hazard     = hazard;
    assign bus.out_valid  = out_valid_q;
    assign bus.op0        = op0_q;
    assign bus.op1        = op1_q;
    assign bus.hazard_cnt = hazard_cnt_q;

endmodule
